// File: rtl/pow_rr_pkg.sv
// Shared types and helpers for the round-robin pow scheduler: FSM states,
// the round-robin pick function and the pow (2**a) reference function.
package pow_rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int MAX_REQ = 8;
  localparam int PICK_W  = 3;
  localparam int CAND_W  = PICK_W + 1;

  typedef struct packed {
    logic              hit;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // First valid index scanning upward from ptr, wrapping at n-1 -> 0.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [PICK_W-1:0]  ptr,
                                    input int unsigned        n);
    pick_t             res;
    logic [CAND_W-1:0] cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = {1'b0, ptr} + CAND_W'(k);
      if (32'(cand) >= n) cand = cand - CAND_W'(n);
      else                cand = cand;
      if (!res.hit && (k < n) && valid[cand[PICK_W-1:0]]) begin
        res.hit = 1'b1;
        res.idx = cand[PICK_W-1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Datapath function: b = 2**a, wrapping to zero once a reaches the word width.
  function automatic logic [63:0] pow2(input logic [63:0] a);
    if (a < 64'd64) return 64'd1 << a[5:0];
    else            return 64'd0;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    else               return v + 16'd1;
  endfunction

endpackage

// File: rtl/pow_tag_pipe.sv
// Fixed-latency {valid, id} delay line that travels alongside the pow datapath
// so each result can be routed back to the requester that issued it.
module pow_tag_pipe #(
  parameter int LAT  = 1,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            valid_i,
  input  logic [ID_W-1:0] id_i,
  output logic            out_valid_o,
  output logic [ID_W-1:0] out_id_o,
  output logic            any_valid_o
);

  logic [LAT-1:0]           vld_q;
  logic [LAT-1:0][ID_W-1:0] id_q;

  // Shift the tag one stage per cycle; reset empties the line.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= valid_i;
      id_q[0]  <= id_i;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
    end
  end

  assign out_valid_o = vld_q[LAT-1];
  assign out_id_o    = id_q[LAT-1];
  assign any_valid_o = |vld_q;

endmodule

// File: rtl/pow_rr_scheduler.sv
// Round-robin front end sharing one pipelined pow datapath among N_REQ requesters.
// Define POW_RR_STATS_EN to add saturating per-requester grant counters.
module pow_rr_scheduler
  import pow_rr_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int POW_LAT = 1,
  parameter int DW      = 32
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                en,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_b,
  output logic                busy
`ifdef POW_RR_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [N_REQ*16-1:0] grant_cnt
`endif
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t                      state_q;
  logic [ID_W-1:0]             ptr_q, ptr_d;
  logic [POW_LAT-1:0][DW-1:0]  op_q;
  logic [N_REQ-1:0]            rsp_valid_q;
  logic [DW-1:0]               rsp_b_q;

  logic [MAX_REQ-1:0]          vld_s;
  pick_t                       pick_s;
  logic                        fire_s;
  logic [ID_W-1:0]             gnt_id_s;
  logic [DW-1:0]               issue_a_s;
  logic [DW-1:0]               pow_b_s;
  logic                        tag_out_valid_s;
  logic [ID_W-1:0]             tag_out_id_s;
  logic                        tag_any_s;

  // Arbitration: grants only in RUN with en high; the pointer advances past the winner.
  always_comb begin
    if ((state_q == RUN) && en) vld_s = MAX_REQ'(req_valid);
    else                        vld_s = '0;
    pick_s   = rr_pick(vld_s, PICK_W'(ptr_q), N_REQ);
    fire_s   = pick_s.hit;
    gnt_id_s = ID_W'(pick_s.idx);
    if (fire_s) begin
      req_ready = N_REQ'(1'b1) << gnt_id_s;
      ptr_d     = (gnt_id_s == ID_W'(N_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
    end else begin
      req_ready = '0;
      ptr_d     = ptr_q;
    end
    issue_a_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id_s == ID_W'(i)) issue_a_s = req_a[i*DW +: DW];
      else                      issue_a_s = issue_a_s;
    end
  end

  // Mode FSM: RUN grants, DRAIN lets in-flight ops finish after en drops.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    state_q <= en ? RUN : IDLE;
        RUN:     state_q <= en ? RUN : (tag_any_s ? DRAIN : IDLE);
        DRAIN:   state_q <= en ? RUN : (tag_any_s ? DRAIN : IDLE);
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pointer, issue register (stage 0 of pow) and the remaining pow pipeline stages.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q <= '0;
      op_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (fire_s) op_q[0] <= issue_a_s;
      for (int k = 1; k < POW_LAT; k++) op_q[k] <= op_q[k-1];
    end
  end

  assign pow_b_s = DW'(pow2(64'(op_q[POW_LAT-1])));

  pow_tag_pipe #(
    .LAT  (POW_LAT),
    .ID_W (ID_W)
  ) u_tag_pipe (
    .clk         (clk),
    .aresetn     (aresetn),
    .valid_i     (fire_s),
    .id_i        (gnt_id_s),
    .out_valid_o (tag_out_valid_s),
    .out_id_o    (tag_out_id_s),
    .any_valid_o (tag_any_s)
  );

  // Response decode: one-cycle pulse to the tagged requester; data holds between pulses.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid_q <= '0;
      rsp_b_q     <= '0;
    end else if (tag_out_valid_s) begin
      rsp_valid_q <= N_REQ'(1'b1) << tag_out_id_s;
      rsp_b_q     <= pow_b_s;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_b     = rsp_b_q;
  assign busy      = tag_any_s | (state_q == DRAIN);

`ifdef POW_RR_STATS_EN
  logic [N_REQ-1:0][15:0] cnt_q;

  // Grant counters; a clear beats a grant in the same cycle.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (stats_clr) begin
      cnt_q <= '0;
    end else if (fire_s) begin
      cnt_q[gnt_id_s] <= sat_inc16(cnt_q[gnt_id_s]);
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pow_rr_scheduler.sv
// Directed bench for pow_rr_scheduler (N_REQ=4, POW_LAT=3, DW=32); pow(a) = 2**a.
module tb_pow_rr_scheduler;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int W   = 32;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] b;
  } rsp_t;

  logic             clk;
  logic             aresetn;
  logic             en;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_b;
  logic             busy;
`ifdef POW_RR_STATS_EN
  logic             stats_clr;
  logic [N*16-1:0]  grant_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  pow_rr_scheduler #(.N_REQ(N), .POW_LAT(LAT), .DW(W)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_b     (rsp_b),
    .busy      (busy)
`ifdef POW_RR_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] pow_ref(input int a);
    if (a < 32) return 32'd1 << a;
    else        return 32'd0;
  endfunction

  function automatic int model_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    aresetn = 1'b0; en = 1'b1; req_valid = '0; req_a = '0;
    #3;
    n_checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || rsp_b !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b rsp=%b b=%h busy=%b, expected all zero", req_ready, rsp_valid, rsp_b, busy);
    end
    @(negedge clk); @(negedge clk);
    aresetn = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got rsp=%b busy=%b, expected 0000/0", k, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_all_valid();
    rsp_t q[$];
    rsp_t e;
    logic [3:0] exp_v;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due == k) begin
        e = q.pop_front();
        exp_v = 4'b0001 << e.id;
        n_checks++;
        if (rsp_valid !== exp_v || rsp_b !== e.b) begin
          n_fail++;
          $display("FAIL rr_rsp cyc %0d: got %b/%h, expected %b/%h", k, rsp_valid, rsp_b, exp_v, e.b);
        end
      end else begin
        n_checks++;
        if (rsp_valid !== 4'b0) begin
          n_fail++;
          $display("FAIL rr_norsp cyc %0d: got %b, expected 0000", k, rsp_valid);
        end
      end
      if (k < 8) begin
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) req_a[i*W +: W] = 32'(i + 1);
      end else begin
        req_valid = 4'h0;
      end
      #1;
      if (k < 8) begin
        exp_v = 4'b0001 << (k % 4);
        n_checks++;
        if (req_ready !== exp_v) begin
          n_fail++;
          $display("FAIL rr_grant cyc %0d: got %b, expected %b", k, req_ready, exp_v);
        end
        q.push_back('{due: k + LAT + 1, id: k % 4, b: pow_ref((k % 4) + 1)});
        m_ptr = (k + 1) % 4;
      end
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_lost: got %0d responses missing, expected 0", q.size());
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[2*W +: W] = 32'd3;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: got %b, expected 0100", req_ready);
    end
    m_ptr = 3;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      req_valid = 4'b0;
      n_checks++;
      if (j == 4) begin
        if (rsp_valid !== 4'b0100 || rsp_b !== 32'd8) begin
          n_fail++;
          $display("FAIL single_rsp: got %b/%h, expected 0100/00000008", rsp_valid, rsp_b);
        end
      end else if (rsp_valid !== 4'b0) begin
        n_fail++;
        $display("FAIL single_norsp j=%0d: got %b, expected 0000", j, rsp_valid);
      end
      n_checks++;
      if (busy !== (j <= 3)) begin
        n_fail++;
        $display("FAIL single_busy j=%0d: got %b, expected %b", j, busy, (j <= 3));
      end
    end
  endtask

  task automatic test_random();
    rsp_t q[$];
    rsp_t e;
    logic [3:0]  pend;
    logic [31:0] av [4];
    int          wait_c [4];
    logic [3:0]  exp_v;
    int          g;
    pend = 4'b0;
    for (int i = 0; i < 4; i++) begin
      av[i] = 32'd0;
      wait_c[i] = 0;
    end
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due == k) begin
        e = q.pop_front();
        exp_v = 4'b0001 << e.id;
        n_checks++;
        if (rsp_valid !== exp_v || rsp_b !== e.b) begin
          n_fail++;
          $display("FAIL rand_rsp cyc %0d: got %b/%h, expected %b/%h", k, rsp_valid, rsp_b, exp_v, e.b);
        end
      end else begin
        n_checks++;
        if (rsp_valid !== 4'b0) begin
          n_fail++;
          $display("FAIL rand_dup cyc %0d: got %b, expected 0000", k, rsp_valid);
        end
      end
      if (k < 100) begin
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && $urandom_range(1, 0) == 1) begin
            pend[i] = 1'b1;
            av[i] = 32'($urandom_range(25, 0));
          end
        end
      end
      req_valid = pend;
      for (int i = 0; i < 4; i++) req_a[i*W +: W] = av[i];
      #1;
      g = model_pick(pend, m_ptr);
      exp_v = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      n_checks++;
      if (req_ready !== exp_v) begin
        n_fail++;
        $display("FAIL rand_grant cyc %0d: got %b, expected %b", k, req_ready, exp_v);
      end
      if (g >= 0) begin
        q.push_back('{due: k + LAT + 1, id: g, b: pow_ref(int'(av[g]))});
        pend[g] = 1'b0;
        wait_c[g] = 0;
        for (int i = 0; i < 4; i++) begin
          if (pend[i]) begin
            wait_c[i]++;
            n_checks++;
            if (wait_c[i] > N - 1) begin
              n_fail++;
              $display("FAIL rand_starve req %0d: got %0d grants waited, expected <= %0d", i, wait_c[i], N - 1);
            end
          end
        end
        m_ptr = (g + 1) % 4;
      end
    end
    req_valid = 4'b0;
    n_checks++;
    if (q.size() != 0 || pend !== 4'b0) begin
      n_fail++;
      $display("FAIL rand_lost: got %0d outstanding, pending %b, expected 0/0000", q.size(), pend);
    end
  endtask

  task automatic test_drain();
    int ids [3];
    logic [3:0] exp_v;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 4 && k <= 6) begin
        exp_v = 4'b0001 << ids[k-4];
        n_checks++;
        if (rsp_valid !== exp_v || rsp_b !== pow_ref(ids[k-4] + 10)) begin
          n_fail++;
          $display("FAIL drain_rsp k=%0d: got %b/%h, expected %b/%h", k, rsp_valid, rsp_b, exp_v, pow_ref(ids[k-4] + 10));
        end
      end else begin
        n_checks++;
        if (rsp_valid !== 4'b0) begin
          n_fail++;
          $display("FAIL drain_norsp k=%0d: got %b, expected 0000", k, rsp_valid);
        end
      end
      if (k >= 3) begin
        n_checks++;
        if (busy !== (k <= 6)) begin
          n_fail++;
          $display("FAIL drain_busy k=%0d: got %b, expected %b", k, busy, (k <= 6));
        end
      end
      en = (k < 3);
      req_valid = 4'hF;
      for (int i = 0; i < N; i++) req_a[i*W +: W] = 32'(i + 10);
      #1;
      if (k < 3) begin
        ids[k] = m_ptr;
        exp_v = 4'b0001 << m_ptr;
        m_ptr = (m_ptr + 1) % 4;
      end else begin
        exp_v = 4'b0000;
      end
      n_checks++;
      if (req_ready !== exp_v) begin
        n_fail++;
        $display("FAIL drain_grant k=%0d: got %b, expected %b", k, req_ready, exp_v);
      end
    end
    @(negedge clk);
    req_valid = 4'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    en = 1'b1;
    req_valid = 4'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 4'hF;
      for (int i = 0; i < N; i++) req_a[i*W +: W] = 32'(i + 20);
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << m_ptr)) begin
        n_fail++;
        $display("FAIL arst_pregrant k=%0d: got %b, expected %b", k, req_ready, 4'b0001 << m_ptr);
      end
      m_ptr = (m_ptr + 1) % 4;
    end
    @(negedge clk);
    aresetn = 1'b0;
    req_valid = 4'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0 || rsp_b !== 32'd0) begin
      n_fail++;
      $display("FAIL arst_in_reset: got rsp=%b busy=%b b=%h, expected 0000/0/0", rsp_valid, busy, rsp_b);
    end
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    m_ptr = 0;
`ifdef POW_RR_STATS_EN
    n_checks++;
    if (grant_cnt !== 64'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %h, expected 0", grant_cnt);
    end
`endif
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_norsp k=%0d: got rsp=%b busy=%b, expected 0000/0", k, rsp_valid, busy);
      end
    end
    @(negedge clk);
    req_valid = 4'hF;
    req_a[0 +: W] = 32'd5;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL arst_ptr0: got %b, expected 0001", req_ready);
    end
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      req_valid = 4'b0;
`ifdef POW_RR_STATS_EN
      if (j == 1) begin
        n_checks++;
        if (grant_cnt !== 64'd1) begin
          n_fail++;
          $display("FAIL stats_count: got %h, expected 1", grant_cnt);
        end
        stats_clr = 1'b1;
        req_valid = 4'hF;
      end else if (j == 2) begin
        stats_clr = 1'b0;
        n_checks++;
        if (grant_cnt !== 64'd0) begin
          n_fail++;
          $display("FAIL stats_clear: got %h, expected 0", grant_cnt);
        end
      end
`endif
      if (j == 4) begin
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_b !== 32'd32) begin
          n_fail++;
          $display("FAIL arst_rsp: got %b/%h, expected 0001/00000020", rsp_valid, rsp_b);
        end
      end
    end
  endtask

  initial begin
`ifdef POW_RR_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_all_valid();
    test_single();
    test_random();
    test_drain();
    test_async_reset();
    repeat (6) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
